reg_dispatch: RTL and testbench

- Write-back dispatcher, the counterpart of the source-select general register: the register captures one of 8 sources; this block delivers 8-bit results to one of 8 destinations.
- Producers push (data, destination) pairs into an internal FIFO.
- The head entry is offered to exactly one destination over a per-destination valid/ready handshake.
- A programmable timeout drops entries a destination never accepts, so a dead peripheral cannot stall the write-back path.

---
 rtl/reg_dispatch_pkg.sv | 30 +++
 rtl/reg_dispatch_fifo.sv | 55 +++++
 rtl/reg_dispatch.sv | 133 +++++++++++++
 tb/tb_reg_dispatch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dispatch_pkg.sv
// reg_dispatch_pkg: shared widths, FIFO entry layout and FSM state type for
// the write-back dispatcher (reg_dispatch) and its queue (dispatch_fifo).
package reg_dispatch_pkg;

    localparam int DATA_W  = 8;   // result width
    localparam int SEL_W   = 3;   // destination index width
    localparam int NUM_DST = 8;   // number of destinations

    // One queued result: destination index above the data byte.
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // One-hot offer vector for a destination index.
    function automatic logic [NUM_DST-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_DST-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reg_dispatch_fifo.sv
// dispatch_fifo: synchronous FIFO holding {sel, data} entries awaiting dispatch.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset (empties the queue)
//   push, din   write din at the tail (caller guarantees !full)
//   pop         advance the head (caller guarantees !empty)
//   full, empty registered-count status
//   head        current head entry (valid while !empty)
module dispatch_fifo
    import reg_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ENTRY_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/reg_dispatch.sv
// reg_dispatch: write-back dispatcher. Producers push {data, destination}
// pairs; the head entry is offered to one destination over a valid/ready
// handshake. Offers left unaccepted for TIMEOUT cycles are dropped.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   push_i, data_i, dst_sel_i producer write side
//   push_ready_o              queue not full
//   dst_data_o, dst_valid_o   shared data bus, one-hot offer
//   dst_ready_i               per-destination accept
//   busy_o                    queue non-empty or offer pending
//   clear_i                   clears ovf_o / drop_o
//   ovf_o, drop_o             sticky overflow / timeout-drop flags
//   drop_dst_o                destination of the most recent drop
module reg_dispatch
    import reg_dispatch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [SEL_W-1:0]  dst_sel_i,
    output logic              push_ready_o,
    output logic [DATA_W-1:0] dst_data_o,
    output logic [NUM_DST-1:0] dst_valid_o,
    input  logic [NUM_DST-1:0] dst_ready_i,
    output logic              busy_o,
    input  logic              clear_i,
    output logic              ovf_o,
    output logic              drop_o,
    output logic [SEL_W-1:0]  drop_dst_o
);

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state, state_nxt;
    entry_t            out_q;
    logic [CNT_W-1:0]  timer;
    logic              ovf_q, drop_q;
    logic [SEL_W-1:0]  drop_dst_q;

    logic              fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic              push_ok, ovf_set;
    logic              pop, xfer, expire;

    assign push_ok = push_i && !fifo_full;
    assign ovf_set = push_i && fifo_full;

    dispatch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_ok),
        .din   ({dst_sel_i, data_i}),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state, pop and offer outputs. A released offer (transfer or
    // expiry) reloads from the queue on the same edge when it is non-empty.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        xfer        = 1'b0;
        expire      = 1'b0;
        dst_valid_o = '0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                dst_valid_o = sel_onehot(out_q.sel);
                xfer        = dst_ready_i[out_q.sel];
                expire      = (TIMEOUT != 0) && !xfer && (timer == TIMER_LAST);
                if (xfer || expire) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= '0;
            timer <= '0;
        end else begin
            if (pop) out_q <= entry_t'(fifo_head);
            if (pop || xfer || expire) timer <= '0;
            else if (state == ST_OFFER) timer <= timer + 1'b1;
        end
    end

    // Sticky flags: a set event in the same cycle as clear_i wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
            drop_dst_q <= '0;
        end else begin
            if (ovf_set)      ovf_q <= 1'b1;
            else if (clear_i) ovf_q <= 1'b0;
            if (expire)       drop_q <= 1'b1;
            else if (clear_i) drop_q <= 1'b0;
            if (expire)       drop_dst_q <= out_q.sel;
        end
    end

    assign push_ready_o = !fifo_full;
    assign dst_data_o   = out_q.data;
    assign busy_o       = !fifo_empty || (state == ST_OFFER);
    assign ovf_o        = ovf_q;
    assign drop_o       = drop_q;
    assign drop_dst_o   = drop_dst_q;

endmodule

// File: tb/tb_reg_dispatch.sv
module tb_reg_dispatch;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rstn;
    logic       push_i;
    logic [7:0] data_i;
    logic [2:0] dst_sel_i;
    logic       push_ready_o;
    logic [7:0] dst_data_o;
    logic [7:0] dst_valid_o;
    logic [7:0] dst_ready_i;
    logic       busy_o;
    logic       clear_i;
    logic       ovf_o;
    logic       drop_o;
    logic [2:0] drop_dst_o;

    reg_dispatch #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (5)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .push_i       (push_i),
        .data_i       (data_i),
        .dst_sel_i    (dst_sel_i),
        .push_ready_o (push_ready_o),
        .dst_data_o   (dst_data_o),
        .dst_valid_o  (dst_valid_o),
        .dst_ready_i  (dst_ready_i),
        .busy_o       (busy_o),
        .clear_i      (clear_i),
        .ovf_o        (ovf_o),
        .drop_o       (drop_o),
        .drop_dst_o   (drop_dst_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of waiting results plus the entry on offer.
    logic [10:0] mq[$];
    bit          m_offer;
    logic [2:0]  m_sel;
    logic [7:0]  m_data;
    int          m_age;
    bit          m_ovf, m_drop;
    logic [2:0]  m_drop_dst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_offer    = 0;
        m_sel      = '0;
        m_data     = '0;
        m_age      = 0;
        m_ovf      = 0;
        m_drop     = 0;
        m_drop_dst = '0;
    endtask

    // One clock edge of the dispatcher's behaviour, from the current inputs.
    task automatic model_edge();
        bit    free_slot;
        bit    was_full;
        int    pre_size;
        pre_size = mq.size();
        was_full = (pre_size == DEPTH);
        free_slot = !m_offer;
        if (m_offer) begin
            if (dst_ready_i[m_sel]) begin
                m_offer   = 0;
                free_slot = 1;
            end else if (m_age == TIMEOUT - 1) begin
                m_offer    = 0;
                free_slot  = 1;
                m_drop     = 1;
                m_drop_dst = m_sel;
            end else begin
                m_age++;
            end
        end
        if (free_slot && pre_size > 0) begin
            logic [10:0] e;
            e       = mq.pop_front();
            m_offer = 1;
            m_sel   = e[10:8];
            m_data  = e[7:0];
            m_age   = 0;
        end
        if (push_i && !was_full) mq.push_back({dst_sel_i, data_i});
        if (push_i && was_full) m_ovf = 1;
        else if (clear_i && !(m_offer && 0)) begin
            if (clear_i) m_ovf = 0;
        end
        if (clear_i && !(m_drop && m_drop_dst == m_sel && 0)) begin
            // a drop on this very edge already set m_drop above; keep it
        end
    endtask

    // Sticky-flag clear must not undo a drop recorded on the same edge, so
    // the drop event is tracked explicitly around model_edge.
    task automatic step();
        bit drop_before;
        bit dropped;
        @(posedge clk);
        drop_before = m_drop;
        m_drop      = 0;
        model_edge();
        dropped = m_drop;
        m_drop  = dropped ? 1'b1 : (clear_i ? 1'b0 : drop_before);
        @(negedge clk);
        compare_all();
    endtask

    task automatic compare_all();
        chk("push_ready", push_ready_o, mq.size() < DEPTH);
        chk("dst_valid", dst_valid_o, m_offer ? (8'h01 << m_sel) : 8'h00);
        if (m_offer) chk("dst_data", dst_data_o, m_data);
        chk("busy", busy_o, (mq.size() != 0) || m_offer);
        chk("ovf", ovf_o, m_ovf);
        chk("drop", drop_o, m_drop);
        chk("drop_dst", drop_dst_o, m_drop_dst);
    endtask

    task automatic push_one(input logic [2:0] sel, input logic [7:0] data);
        push_i    = 1'b1;
        dst_sel_i = sel;
        data_i    = data;
        step();
        push_i    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn        = 1'b0;
        push_i      = 1'b0;
        data_i      = '0;
        dst_sel_i   = '0;
        dst_ready_i = '0;
        clear_i     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_push_ready", push_ready_o, 1'b1);
        chk("rst_dst_data", dst_data_o, 8'h00);
        chk("rst_dst_valid", dst_valid_o, 8'h00);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ovf", ovf_o, 1'b0);
        chk("rst_drop", drop_o, 1'b0);
        chk("rst_drop_dst", drop_dst_o, 3'd0);
        rstn = 1'b1;

        // Single push, sel 3, data 0xA5, destination ready held
        dst_ready_i = 8'h08;
        push_one(3'd3, 8'hA5);
        chk("single_latency_valid0", dst_valid_o, 8'h00);
        step();
        chk("single_valid", dst_valid_o, 8'h08);
        chk("single_data", dst_data_o, 8'hA5);
        step();
        chk("single_done_valid", dst_valid_o, 8'h00);
        chk("single_done_busy", busy_o, 1'b0);

        // Fill: one entry on offer plus DEPTH queued, then overflow
        dst_ready_i = 8'h00;
        for (int i = 0; i < 5; i++) push_one(3'(i), 8'h10 + 8'(i));
        chk("fill_full", push_ready_o, 1'b0);
        push_one(3'd7, 8'hEE);
        chk("ovf_set", ovf_o, 1'b1);
        dst_ready_i = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            chk("b2b_valid", dst_valid_o, 8'h01 << i);
            chk("b2b_data", dst_data_o, 8'h10 + 8'(i));
            step();
        end
        chk("b2b_end_valid", dst_valid_o, 8'h00);
        chk("b2b_end_busy", busy_o, 1'b0);

        // Timeout: sel 5 never accepted
        dst_ready_i = 8'hDF;
        push_one(3'd5, 8'h77);
        step();
        n = 0;
        while (dst_valid_o == 8'h20 && n < 40) begin
            n++;
            step();
        end
        chk("timeout_offer_cycles", n, TIMEOUT);
        chk("timeout_drop", drop_o, 1'b1);
        chk("timeout_drop_dst", drop_dst_o, 3'd5);
        chk("timeout_valid", dst_valid_o, 8'h00);

        // Clear with both flags set and no new events
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clear_ovf", ovf_o, 1'b0);
        chk("clear_drop", drop_o, 1'b0);

        // Accept on the expiry cycle wins over the drop
        dst_ready_i = 8'h00;
        push_one(3'd5, 8'h66);
        step();
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        chk("expiry_still_valid", dst_valid_o, 8'h20);
        dst_ready_i = 8'h20;
        step();
        chk("expiry_xfer_drop", drop_o, 1'b0);
        chk("expiry_xfer_valid", dst_valid_o, 8'h00);

        // Clear coinciding with an overflow push: set wins
        dst_ready_i = 8'h00;
        for (int i = 0; i < 5; i++) push_one(3'(i + 1), 8'h40 + 8'(i));
        clear_i = 1'b1;
        push_one(3'd0, 8'hCC);
        clear_i = 1'b0;
        chk("clear_vs_ovf", ovf_o, 1'b1);

        // Asynchronous reset mid-offer with entries queued
        #1 rstn = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", dst_valid_o, 8'h00);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_drop", drop_o, 1'b0);
        chk("arst_ovf", ovf_o, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        chk("arst_push_ready", push_ready_o, 1'b1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            push_i    = ($urandom_range(0, 2) != 0);
            dst_sel_i = 3'($urandom_range(0, 7));
            data_i    = 8'($urandom);
            clear_i   = ($urandom_range(0, 15) == 0);
            if ((i / 60) % 3 == 2) dst_ready_i = ($urandom_range(0, 39) == 0) ? 8'($urandom) : 8'h00;
            else                   dst_ready_i = 8'($urandom);
            step();
        end
        push_i  = 1'b0;
        clear_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
